// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, key bit positions, receiver states and the
// (ext, code) -> key bit lookup used by the decode layer.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam int NUM_KEYS  = 5;
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_SPACE = 4;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_map_t;

  // Arrow codes only count with the E0 prefix; the bare codes are keypad keys.
  function automatic key_map_t key_lookup(input logic ext, input logic [7:0] code);
    key_map_t m;
    m.hit = 1'b0;
    m.idx = 3'd0;
    if (ext) begin
      case (code)
        SC_LEFT:  begin m.hit = 1'b1; m.idx = 3'(KEY_LEFT);  end
        SC_RIGHT: begin m.hit = 1'b1; m.idx = 3'(KEY_RIGHT); end
        SC_UP:    begin m.hit = 1'b1; m.idx = 3'(KEY_UP);    end
        SC_DOWN:  begin m.hit = 1'b1; m.idx = 3'(KEY_DOWN);  end
        default:  ;
      endcase
    end else if (code == SC_SPACE) begin
      m.hit = 1'b1;
      m.idx = 3'(KEY_SPACE);
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deframer: synchronizer, stability filter, 11-bit frame
// FSM with mid-frame timeout. Emits one-cycle byte_valid / frame_err pulses.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]     sync_p0, sync_p1;
  logic [1:0]     filt;
  logic [FCW-1:0] fcnt [2];
  logic           clk_prev;
  logic           fall;
  logic           din;

  rx_state_t      state;
  logic [2:0]     bit_cnt;
  logic           parity_ok;
  logic [TW-1:0]  timer;
  logic [7:0]     shreg;

  // Stage p0/p1: two-flop synchronizer; then a per-line stability filter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0  <= 2'b11;
      sync_p1  <= 2'b11;
      filt     <= 2'b11;
      clk_prev <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync_p0  <= {ps2_data, ps2_clk};
      sync_p1  <= sync_p0;
      clk_prev <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          filt[i] <= sync_p1[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall = clk_prev & ~filt[0];
  assign din  = filt[1];

  // Frame FSM: one step per filtered falling edge, timer guards partial frames
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      parity_ok  <= 1'b0;
      timer      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        timer <= '0;
        if (fall) begin
          if (!din) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (fall) begin
        timer <= '0;
        case (state)
          DATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_ok <= ^{shreg, din};
            state     <= STOP;
          end
          default: begin
            if (din && parity_ok) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        endcase
      end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        timer     <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Data shift register carries no reset; it is only read after a full frame
  always_ff @(posedge clk) begin
    if (state == DATA && fall) shreg <= {din, shreg[7:1]};
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: deframes bytes and tracks set-2 make/break codes
// for the arrow keys and space into a held-key bitmap.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  output logic                frame_err
);

  logic                ext, brk;
  key_map_t            map;
  logic [NUM_KEYS-1:0] mask;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign map  = key_lookup(ext, byte_data);
  assign mask = NUM_KEYS'(1) << map.idx;

  // Decode stage: prefix bytes arm ext/brk, any other byte consumes them
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      key_pressed <= '0;
    end else if (byte_valid) begin
      if (byte_data == SC_EXT) begin
        ext <= 1'b1;
      end else if (byte_data == SC_BRK) begin
        brk <= 1'b1;
      end else begin
        if (map.hit) key_pressed <= brk ? (key_pressed & ~mask) : (key_pressed | mask);
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: each sent frame pushes its expected byte/error and key
// bitmap; a negedge monitor pops and compares as the decoder produces them.
module tb_ps2_key_decoder;

  localparam int TO   = 1000;
  localparam int HALF = 20;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic [4:0] keys;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [4:0] key_pressed;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int bv_count = 0;

  exp_t       q[$];
  exp_t       e;
  logic [4:0] m_keys = '0;
  bit         m_ext = 0, m_brk = 0;
  logic [7:0] m_last = '0;
  bit         key_pend = 0;
  logic [4:0] key_exp = '0;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_pressed (key_pressed),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_err   (frame_err)
  );

  always @(negedge clk) begin
    if (key_pend) begin
      checks++;
      if (key_pressed !== key_exp) begin
        failures++;
        $display("FAIL keys_after_byte: got %b want %b", key_pressed, key_exp);
      end
      key_pend = 0;
    end
    if (byte_valid === 1'b1 || frame_err === 1'b1) begin
      if (byte_valid === 1'b1) bv_count++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: byte_valid=%b frame_err=%b data=%h", byte_valid, frame_err, byte_data);
      end else begin
        e = q.pop_front();
        if ({frame_err, byte_valid} !== {e.is_err, ~e.is_err}) begin
          failures++;
          $display("FAIL event_kind: got err=%b valid=%b want err=%b", frame_err, byte_valid, e.is_err);
        end
        if (!e.is_err) begin
          checks++;
          if (byte_data !== e.data) begin
            failures++;
            $display("FAIL byte_data: got %h want %h", byte_data, e.data);
          end
        end
        key_pend = 1;
        key_exp  = e.keys;
      end
    end
  end

  function automatic void push_byte(input logic [7:0] b);
    int idx;
    exp_t x;
    idx = -1;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (m_ext) begin
        case (b)
          8'h6B: idx = 0;
          8'h74: idx = 1;
          8'h75: idx = 2;
          8'h72: idx = 3;
          default: idx = -1;
        endcase
      end else if (b == 8'h29) idx = 4;
      if (idx >= 0) m_keys[idx] = ~m_brk;
      m_ext = 0;
      m_brk = 0;
    end
    m_last   = b;
    x.is_err = 0;
    x.data   = b;
    x.keys   = m_keys;
    q.push_back(x);
  endfunction

  function automatic void push_err();
    exp_t x;
    x.is_err = 1;
    x.data   = '0;
    x.keys   = m_keys;
    q.push_back(x);
  endfunction

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_parity);
    if (flip_parity) push_err();
    else push_byte(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ flip_parity);
    send_bit(1'b1);
    repeat (3 * HALF) @(posedge clk);
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && !key_pend) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({key_pressed, byte_valid, byte_data, frame_err} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got keys=%b bv=%b data=%h err=%b want 0", key_pressed, byte_valid, byte_data, frame_err);
    end
    rstn = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if ({key_pressed, byte_valid, byte_data, frame_err} !== 15'd0) begin
      failures++;
      $display("FAIL idle_after_reset: got keys=%b bv=%b data=%h err=%b want 0", key_pressed, byte_valid, byte_data, frame_err);
    end
  endtask

  task automatic test_space_make_break();
    int bv0;
    bit ok;
    bv0 = bv_count;
    send_frame(8'h29, 0);
    #1;
    checks++;
    if (key_pressed !== 5'b10000) begin
      failures++;
      $display("FAIL space_make: got %b want %b", key_pressed, 5'b10000);
    end
    send_frame(8'hF0, 0);
    send_frame(8'h29, 0);
    drain(ok);
    checks++;
    if (!ok || key_pressed !== 5'b00000 || bv_count - bv0 != 3) begin
      failures++;
      $display("FAIL space_break: ok=%b keys=%b pulses=%0d want keys 00000 pulses 3", ok, key_pressed, bv_count - bv0);
    end
  endtask

  task automatic test_arrows();
    bit ok;
    send_frame(8'hE0, 0); send_frame(8'h6B, 0);
    send_frame(8'hE0, 0); send_frame(8'h74, 0);
    #1;
    checks++;
    if (key_pressed !== 5'b00011) begin
      failures++;
      $display("FAIL arrows_make: got %b want %b", key_pressed, 5'b00011);
    end
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h6B, 0);
    drain(ok);
    checks++;
    if (!ok || key_pressed !== 5'b00010) begin
      failures++;
      $display("FAIL arrows_break: ok=%b got %b want %b", ok, key_pressed, 5'b00010);
    end
  endtask

  task automatic test_unmapped();
    bit ok;
    send_frame(8'h6B, 0);
    send_frame(8'hE0, 0); send_frame(8'h1C, 0); send_frame(8'h75, 0);
    send_frame(8'hF0, 0); send_frame(8'h1C, 0); send_frame(8'h29, 0);
    send_frame(8'h29, 0);
    drain(ok);
    checks++;
    if (!ok || key_pressed !== m_keys) begin
      failures++;
      $display("FAIL unmapped_flags: ok=%b got %b want %b", ok, key_pressed, m_keys);
    end
  endtask

  task automatic test_parity_error();
    bit ok;
    send_frame(8'h1C, 1);
    drain(ok);
    checks++;
    if (!ok || byte_data !== m_last) begin
      failures++;
      $display("FAIL parity_err_hold: ok=%b data=%h want %h", ok, byte_data, m_last);
    end
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    drain(ok);
    checks++;
    if (!ok || key_pressed[2] !== 1'b1) begin
      failures++;
      $display("FAIL up_after_err: ok=%b keys=%b want bit2 set", ok, key_pressed);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [7:0] b;
    b = 8'h29;
    push_err();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    repeat (TO + HALF + 20) @(posedge clk);
    drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_err: pending=%0d want 0", q.size());
    end
    send_frame(8'hF0, 0); send_frame(8'h29, 0);
    send_frame(8'h29, 0);
    drain(ok);
    checks++;
    if (!ok || key_pressed !== m_keys) begin
      failures++;
      $display("FAIL after_timeout: ok=%b got %b want %b", ok, key_pressed, m_keys);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    logic [7:0] b;
    b = 8'h72;
    send_frame(8'h29, 0);
    drain(ok);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(b[i]);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({key_pressed, byte_valid, byte_data, frame_err} !== 15'd0) begin
      failures++;
      $display("FAIL async_reset: got keys=%b bv=%b data=%h err=%b want 0", key_pressed, byte_valid, byte_data, frame_err);
    end
    q.delete();
    key_pend = 0;
    m_keys = '0; m_ext = 0; m_brk = 0; m_last = '0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    rstn = 1'b1;
    repeat (30) @(posedge clk);
    send_frame(8'h29, 0);
    drain(ok);
    checks++;
    if (!ok || key_pressed !== 5'b10000) begin
      failures++;
      $display("FAIL space_after_reset: ok=%b got %b want %b", ok, key_pressed, 5'b10000);
    end
  endtask

  initial begin
    #600us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_space_make_break();
    test_arrows();
    test_unmapped();
    test_parity_error();
    test_timeout();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives raw PS/2 keyboard clock/data, deframes 11-bit device-to-host frames, and tracks make/break scan codes (set 2) into a held-key bitmap. Sits directly upstream of the paddle/graph logic and replaces the keyboard front end that drives the 5-bit key vector. Also exposes each received byte and a frame-error pulse for debug and LED display.

## Interface
- `FILTER_LEN`, 8: consecutive identical `clk` samples required before a filtered PS2 line level changes.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a falling edge mid-frame before the frame is aborted.
- `clk`  in  1  system clock (100 MHz).
- `rstn`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock from the pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the pin, asynchronous.
- `key_pressed`  out  5  held keys: [0] left, [1] right, [2] up, [3] down, [4] space.
- `byte_valid`  out  1  one-cycle pulse, good frame received.
- `byte_data`  out  8  last good byte; held until the next `byte_valid`.
- `frame_err`  out  1  one-cycle pulse on a start, parity or stop error, or on a timeout.

## Operation
- Reset values: `key_pressed`=0, `byte_valid`=0, `byte_data`=0, `frame_err`=0. The receiver FSM is IDLE and both the ext and brk flags are clear.
- Input conditioning:
  - 2-flop synchronizer on each line.
  - Then a `FILTER_LEN` stability filter; the filtered level resets to 1.
  - A falling edge is when the filtered `ps2_clk` goes from 1 to 0.
  - Data is sampled as the filtered `ps2_data` in the same cycle as the edge.
- Receiver FSM, one transition per falling edge:
  - IDLE: sampled 0 → DATA with bit count 0. Sampled 1 → stay IDLE and pulse `frame_err`.
  - DATA: shift in LSB first. After the 8th bit → PARITY.
  - PARITY: check that the 8 data bits plus the parity bit have odd weight. Store the result and go → STOP.
  - STOP: sampled 1 and parity ok → deliver the byte. Otherwise pulse `frame_err`. Either way → IDLE.
- Timeout: in any state other than IDLE, the counter reloads on every edge. If it reaches `TIMEOUT_CYCLES`, go → IDLE, pulse `frame_err` and discard the partial byte.
- Decode layer, on each delivered byte:
  - 0xE0: set ext.
  - 0xF0: set brk.
  - Any other byte: look up (ext, code). If mapped, set the key bit (brk=0) or clear it (brk=1). Then clear both ext and brk, whether or not the code was mapped.
- Map:
  - E0 6B → left.
  - E0 74 → right.
  - E0 75 → up.
  - E0 72 → down.
  - 29 with no ext → space.
  - Non-extended 6B/74/75/72 (keypad keys) are not mapped.
- Repeated make codes (typematic) leave a set bit set.
- A frame error does not touch ext, brk or `key_pressed`.
- Reset mid-frame: all state returns to reset values immediately.

## Timing
- Pin to filtered edge: 2 sync cycles + `FILTER_LEN` cycles.
- `byte_valid` and `byte_data` update in the cycle after the STOP-edge cycle.
- `key_pressed` updates in the cycle after `byte_valid`, so total byte-to-bitmap latency is 2 cycles after the stop edge.
- `frame_err` pulses in the cycle after the offending edge, or after timeout expiry.
- `frame_err` and `byte_valid` are never high together.
- The timeout counter is wide enough for `TIMEOUT_CYCLES`: ≥16 bits at the default.

## Structure
- Shared package `ps2_pkg`:
  - Scan-code constants: E0, F0, 6B, 74, 75, 72, 29.
  - Key bit index constants: KEY_LEFT=0 through KEY_SPACE=4.
  - Receiver state enum: IDLE, DATA, PARITY, STOP.
- Sub-module `ps2_frame_rx` contains sync, filter, receiver FSM and timeout. Its outputs are `byte_valid`, `byte_data` and `frame_err`.
- The top `ps2_key_decoder` holds the ext/brk flags and the bitmap register.

## Test plan
- Send frame 0x29 (odd parity bit 0, stop 1), then F0, then 29 → `key_pressed`=5'b10000 after the first byte, then 0 after the break; `byte_valid` pulses 3 times.
- Send E0 6B, then E0 74 → `key_pressed`=5'b00011. Then send E0 F0 6B → 5'b00010.
- Send 6B without E0 → `byte_valid` pulse with `byte_data`=0x6B, `key_pressed` unchanged, ext/brk cleared.
- Send 0x1C with the parity bit flipped → `frame_err` pulse, no `byte_valid`. A following good E0 75 → bit 2 set.
- Stop clocking after 4 data bits, wait `TIMEOUT_CYCLES`+1 → `frame_err` pulse, FSM IDLE. The next full frame 0x29 decodes correctly.
- Hold space down, assert `rstn`=0 mid-frame → all outputs 0 immediately. After release, a fresh frame 0x29 sets bit 4.
